// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one counter/scaler datapath among NUM_REQ requesters.
// Optional golden-model check of each captured result: define CNT_SCHED_CHECK_EN.
module cnt_sched #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_len,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 dp_reset,
    output logic                 dp_in,
    input  logic [7:0]           dp_out,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [7:0]           resp_data,
    output logic                 resp_err,
    output logic                 busy
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, CLR, RUN, SETTLE, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      rem_q, rem_d;
    logic [SW-1:0]   set_q, set_d;
    logic [7:0]      data_q, data_d;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] scan_idx;
    logic            capture;

    // First requesting index at or after rr_q, wrapping at NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign capture = (state_q == SETTLE) && (set_q == '0);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        len_d     = len_q;
        rem_d     = rem_q;
        set_d     = set_q;
        data_d    = data_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (reset && gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    len_d   = req_len[{gnt_idx, 3'b000} +: 8];
                    id_d    = gnt_idx;
                    rr_d    = (int'(gnt_idx) + 1 == NUM_REQ) ? '0 : gnt_idx + 1'b1;
                    state_d = CLR;
                end
            end
            CLR: begin
                rem_d   = len_q;
                set_d   = SW'(SETTLE_CYC - 1);
                state_d = (len_q != 8'd0) ? RUN : SETTLE;
            end
            RUN: begin
                if (rem_q == 8'd1) begin
                    set_d   = SW'(SETTLE_CYC - 1);
                    state_d = SETTLE;
                end else begin
                    rem_d = rem_q - 8'd1;
                end
            end
            SETTLE: begin
                if (capture) begin
                    data_d  = dp_out;
                    state_d = RESP;
                end else begin
                    set_d = set_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            set_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            set_q   <= set_d;
            data_q  <= data_d;
        end
    end

`ifdef CNT_SCHED_CHECK_EN
    logic [15:0] sq;
    logic [7:0]  exp_val;
    logic        err_q, err_d;

    always_comb begin
        sq = 16'(len_q) * 16'(len_q);
        if (len_q < 8'd4)        exp_val = 8'd0;
        else if (len_q <= 8'd16) exp_val = sq[7:0];
        else                     exp_val = len_q >> 1;
        err_d = err_q;
        if (capture) err_d = (dp_out != exp_val);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (capture && (dp_out != exp_val))
                $display("CNT_SCHED mismatch id=%0d exp=%0h got=%0h", id_q, exp_val, dp_out);
        end
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Clear is forced while reset is low so the datapath never holds a stale count.
    assign dp_reset   = !reset || (state_q == CLR);
    assign dp_in      = !(reset && (state_q == RUN));
    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cnt_sched.sv
// Scoreboard bench for cnt_sched with a behavioural counter/scaler datapath attached.
module tb_cnt_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_len;
    logic [3:0]  req_ready;
    logic        dp_reset, dp_in;
    logic [7:0]  dp_out;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_data;
    logic        resp_err, busy;

    always #5 clk = ~clk;

    cnt_sched #(.NUM_REQ(4), .ID_W(2), .SETTLE_CYC(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len),
        .req_ready(req_ready), .dp_reset(dp_reset), .dp_in(dp_in), .dp_out(dp_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    // Datapath unit: count on dp_in low, output follows the count one cycle later.
    logic [7:0] dcnt, dout;
    logic       dp_force;

    function automatic logic [7:0] dp_func(input logic [7:0] c);
        logic [15:0] s;
        s = 16'(c) * 16'(c);
        if (c < 8'd4)        return 8'd0;
        else if (c <= 8'd16) return s[7:0];
        else                 return c >> 1;
    endfunction

    always @(posedge clk) begin
        if (dp_reset) begin
            dcnt <= 8'd0;
            dout <= 8'd0;
        end else begin
            if (!dp_in) dcnt <= dcnt + 8'd1;
            dout <= dp_func(dcnt);
        end
    end

    assign dp_out = dp_force ? 8'h00 : dout;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
        logic [7:0] len;
    } exp_t;

    exp_t rq[$];
    int   gq[$];

    int checks = 0;
    int errors = 0;
    int tmo = 0;
    int tmo_seen = 0;
    bit done = 1'b0;
    bit done_chk = 1'b0;

    // Monitor state
    int         cyc = 0;
    int         g_cyc = 0, v_cyc = 0, run_cnt = 0, clr_cnt = 0;
    bit         prev_rst = 1'b0, vld_prev = 1'b0;
    logic [1:0] cap_id;
    logic [7:0] cap_data;
    logic       cap_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   g, want;
        cyc++;
        if (!reset) begin
            chk("rst_dp_reset", 32'(dp_reset), 32'd1);
            if (prev_rst) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                chk("rst_req_ready", 32'(req_ready), 32'd0);
            end
            prev_rst = 1'b1;
            vld_prev = 1'b0;
        end else begin
            prev_rst = 1'b0;
            if (req_ready != 4'd0) begin
                chk("grant_onehot", 32'($onehot(req_ready)), 32'd1);
                g = 0;
                for (int i = 3; i >= 0; i--) if (req_ready[i]) g = i;
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 32'(g), 32'hFFFF_FFFF);
                end else begin
                    want = gq.pop_front();
                    chk("grant_id", 32'(g), 32'(want));
                end
                g_cyc = cyc;
                run_cnt = 0;
                clr_cnt = 0;
            end else begin
                if (!dp_in)  run_cnt++;
                if (dp_reset) clr_cnt++;
            end
            if (resp_valid) begin
                chk("no_grant_in_resp", 32'(req_ready), 32'd0);
                if (!vld_prev) begin
                    v_cyc    = cyc;
                    cap_id   = resp_id;
                    cap_data = resp_data;
                    cap_err  = resp_err;
                end else begin
                    chk("stable_id", 32'(resp_id), 32'(cap_id));
                    chk("stable_data", 32'(resp_data), 32'(cap_data));
                    chk("stable_err", 32'(resp_err), 32'(cap_err));
                end
                if (resp_ready) begin
                    if (rq.size() == 0) begin
                        chk("resp_unexpected", 32'(resp_id), 32'hFFFF_FFFF);
                    end else begin
                        e = rq.pop_front();
                        chk("resp_id", 32'(resp_id), 32'(e.id));
                        chk("resp_data", 32'(resp_data), 32'(e.data));
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                        chk("latency", 32'(v_cyc - g_cyc), 32'(int'(e.len) + 4));
                        chk("count_cycles", 32'(run_cnt), 32'(e.len));
                        chk("clear_cycles", 32'(clr_cnt), 32'd1);
                    end
                end
            end
            vld_prev = resp_valid && !resp_ready;
        end
        if (tmo != tmo_seen) begin
            chk("wait_timeout", 32'(tmo), 32'(tmo_seen));
            tmo_seen = tmo;
        end
        if (done && !done_chk) begin
            done_chk = 1'b1;
            chk("grants_left", 32'(gq.size()), 32'd0);
            chk("resps_left", 32'(rq.size()), 32'd0);
        end
    end

    // Stimulus: requests drop only after the posedge that accepted them.
    logic [3:0] gseen;
    logic [3:0] keep = 4'd0;
    int         gcount = 0;
    int         keep_until = 0;

    task automatic tick();
        @(negedge clk);
        gseen = req_ready;
        @(posedge clk);
        #1;
        gcount += $countones(gseen);
        if (gcount >= keep_until) keep = 4'd0;
        req_valid = (req_valid & ~gseen) | keep;
    endtask

    function automatic exp_t mk(input int r, input int l, input logic [7:0] d, input logic er);
        exp_t e;
        e.id = 2'(r); e.data = d; e.err = er; e.len = 8'(l);
        return e;
    endfunction

    task automatic wait_grants(input int budget);
        int n = 0;
        while (req_valid != 4'd0 && n < budget) begin tick(); n++; end
        if (req_valid != 4'd0) begin tmo++; req_valid = 4'd0; end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (rq.size() != 0 && n < budget) begin tick(); n++; end
        if (rq.size() != 0) tmo++;
    endtask

    task automatic job(input int r, input int l, input logic [7:0] d, input logic er);
        req_len[8*r +: 8] = 8'(l);
        gq.push_back(r);
        rq.push_back(mk(r, l, d, er));
        req_valid[r] = 1'b1;
        wait_grants(50);
        wait_drain(300);
    endtask

    initial begin
        reset = 1'b0; req_valid = 4'd0; req_len = 32'd0; resp_ready = 1'b1; dp_force = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Abandon a job with reset in the middle of counting
        req_len[15:8] = 8'd10;
        gq.push_back(1);
        req_valid[1] = 1'b1;
        wait_grants(20);
        repeat (4) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (6) tick();

        // Pointer restarts at 0: requester 0 wins over 3
        req_len[7:0] = 8'd5; req_len[31:24] = 8'd7;
        gq.push_back(0); gq.push_back(3);
        rq.push_back(mk(0, 5, 8'h19, 1'b0));
        rq.push_back(mk(3, 7, 8'h31, 1'b0));
        req_valid = 4'b1001;
        wait_grants(100);
        wait_drain(100);

        job(0, 5, 8'h19, 1'b0);

        job(2, 0,   8'h00, 1'b0);
        job(2, 3,   8'h00, 1'b0);
        job(2, 4,   8'h10, 1'b0);
        job(2, 16,  8'h00, 1'b0);
        job(2, 17,  8'h08, 1'b0);
        job(2, 255, 8'h7F, 1'b0);

        // All four held valid; pointer currently at 3
        req_len = {4{8'd1}};
        gq.push_back(3); gq.push_back(0); gq.push_back(1); gq.push_back(2);
        gq.push_back(3); gq.push_back(0); gq.push_back(1);
        rq.push_back(mk(3, 1, 8'h00, 1'b0)); rq.push_back(mk(0, 1, 8'h00, 1'b0));
        rq.push_back(mk(1, 1, 8'h00, 1'b0)); rq.push_back(mk(2, 1, 8'h00, 1'b0));
        rq.push_back(mk(3, 1, 8'h00, 1'b0)); rq.push_back(mk(0, 1, 8'h00, 1'b0));
        rq.push_back(mk(1, 1, 8'h00, 1'b0));
        keep_until = gcount + 4;
        keep = 4'hF;
        req_valid = 4'hF;
        wait_grants(200);
        wait_drain(100);

        // Consumer stalls 10 cycles with another request pending
        resp_ready = 1'b0;
        req_len[15:8] = 8'd8;
        gq.push_back(1);
        rq.push_back(mk(1, 8, 8'h40, 1'b0));
        req_valid[1] = 1'b1;
        wait_grants(20);
        for (int n = 0; n < 50 && !resp_valid; n++) tick();
        if (!resp_valid) tmo++;
        req_len[31:24] = 8'd4;
        gq.push_back(3);
        rq.push_back(mk(3, 4, 8'h10, 1'b0));
        req_valid[3] = 1'b1;
        repeat (10) tick();
        resp_ready = 1'b1;
        wait_grants(50);
        wait_drain(100);

`ifdef CNT_SCHED_CHECK_EN
        dp_force = 1'b1;
        job(0, 6, 8'h00, 1'b1);
        dp_force = 1'b0;
`else
        job(0, 6, 8'h24, 1'b0);
`endif

        done = 1'b1;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
